// File: rtl/bfc_key_hasher.sv
// bfc_key_hasher
//   Upstream feeder for the Bloom filter counter. Key bytes arrive on a
//   valid/ready stream and are folded into a hash with a rotate-left-1/XOR
//   step. At the end of each key the hash is reduced to an IDX_W-bit index and
//   pushed into a small FIFO. The FIFO is drained one index per cycle onto the
//   counter's enable/inputData pair unless 'hold' is high.
//
//   Optional feature macro: BFC_DUAL_HASH_EN
//     When defined, a second hash register (seeded with SEED2) runs in
//     parallel. Each key then pushes two indices in the same cycle: the
//     primary index first, then the secondary one.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   in_valid     in   key byte valid
//   in_ready     out  byte accepted when in_valid && in_ready
//   in_byte      in   key byte
//   in_last      in   byte is the final byte of the key
//   hold         in   1 = do not pop the FIFO (no out_enable)
//   out_enable   out  one-cycle pulse per delivered index
//   out_data     out  zero-extended index; holds its last value between pulses
//   fifo_level   out  entries currently buffered
//   key_len_err  out  sticky: a key was cut at MAX_KEY_BYTES
module bfc_key_hasher #(
    parameter int unsigned IDX_W         = 4,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned MAX_KEY_BYTES = 4,
    parameter logic [7:0]  SEED          = 8'hA5,
    parameter logic [7:0]  SEED2         = 8'h1D
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [7:0]                    in_byte,
    input  logic                          in_last,
    input  logic                          hold,
    output logic                          out_enable,
    output logic [7:0]                    out_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          key_len_err
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = $clog2(MAX_KEY_BYTES + 1);

`ifdef BFC_DUAL_HASH_EN
    localparam int unsigned PUSH_N = 2;
`else
    localparam int unsigned PUSH_N = 1;
`endif

    // EMIT may push only when the level leaves room for every entry of the key.
    localparam logic [LVL_W-1:0] EMIT_MAX_LVL = LVL_W'(FIFO_DEPTH - PUSH_N);
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(MAX_KEY_BYTES - 1);

    typedef enum logic {
        StAccum,
        StEmit
    } state_e;

    function automatic logic [7:0] hash_step(input logic [7:0] h, input logic [7:0] b);
        return {h[6:0], h[7]} ^ b;
    endfunction

    // Fold the upper hash bits onto the lower ones; for IDX_W = 8 the shift
    // leaves zero and the index is the hash itself.
    function automatic logic [IDX_W-1:0] fold(input logic [7:0] h);
        logic [7:0] t;
        t = h ^ (h >> IDX_W);
        return t[IDX_W-1:0];
    endfunction

    state_e              state_q, state_d;
    logic [7:0]          h_q, h_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;

    logic [IDX_W-1:0]    mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                out_en_q, out_en_d;
    logic [7:0]          out_data_q, out_data_d;

    logic                emit_go;
    logic                pop;

`ifdef BFC_DUAL_HASH_EN
    logic [7:0]          h2_q, h2_d;
`else
    logic                unused_seed2;
    assign unused_seed2 = ^SEED2;
`endif

    assign emit_go = (state_q == StEmit) && (level_q <= EMIT_MAX_LVL);
    assign pop     = (level_q != '0) && !hold;

    // Key accumulation / emit FSM.
    always_comb begin
        state_d  = state_q;
        h_d      = h_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        in_ready = 1'b0;
`ifdef BFC_DUAL_HASH_EN
        h2_d     = h2_q;
`endif
        unique case (state_q)
            StAccum: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    h_d   = hash_step(h_q, in_byte);
`ifdef BFC_DUAL_HASH_EN
                    h2_d  = hash_step(h2_q, in_byte);
`endif
                    cnt_d = cnt_q + CNT_W'(1);
                    if (in_last || (cnt_q == CNT_LAST)) begin
                        state_d = StEmit;
                    end
                    // Length limit hit mid-key: the rest starts a new key.
                    if (!in_last && (cnt_q == CNT_LAST)) begin
                        err_d = 1'b1;
                    end
                end
            end
            StEmit: begin
                if (emit_go) begin
                    h_d     = SEED;
`ifdef BFC_DUAL_HASH_EN
                    h2_d    = SEED2;
`endif
                    cnt_d   = '0;
                    state_d = StAccum;
                end
            end
            default: state_d = StAccum;
        endcase
    end

    // FIFO pointers, level and the registered output stage.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        out_en_d   = 1'b0;
        out_data_d = out_data_q;
        if (emit_go) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(PUSH_N);
            level_d  = level_d + LVL_W'(PUSH_N);
        end
        if (pop) begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            level_d    = level_d - LVL_W'(1);
            out_en_d   = 1'b1;
            out_data_d = 8'(mem_q[rd_ptr_q]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StAccum;
            h_q        <= SEED;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            out_en_q   <= 1'b0;
            out_data_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            h_q        <= h_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            out_en_q   <= out_en_d;
            out_data_q <= out_data_d;
        end
    end

`ifdef BFC_DUAL_HASH_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            h2_q <= SEED2;
        end else begin
            h2_q <= h2_d;
        end
    end
`endif

    // Storage needs no reset; validity is tracked by the pointers and level.
    // A push never targets the head slot while it is being read.
    always_ff @(posedge clk) begin
        if (!reset && emit_go) begin
            mem_q[wr_ptr_q] <= fold(h_q);
`ifdef BFC_DUAL_HASH_EN
            mem_q[wr_ptr_q + PTR_W'(1)] <= fold(h2_q);
`endif
        end
    end

    assign out_enable  = out_en_q;
    assign out_data    = out_data_q;
    assign fifo_level  = level_q;
    assign key_len_err = err_q;

endmodule

// File: tb/tb_bfc_key_hasher.sv
module tb_bfc_key_hasher;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_byte = 8'h00;
    logic       in_last = 1'b0;
    logic       hold = 1'b0;
    logic       out_enable;
    logic [7:0] out_data;
    logic [2:0] fifo_level;
    logic       key_len_err;

    int         n_tests = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    bfc_key_hasher dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_byte     (in_byte),
        .in_last     (in_last),
        .hold        (hold),
        .out_enable  (out_enable),
        .out_data    (out_data),
        .fifo_level  (fifo_level),
        .key_len_err (key_len_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every delivered index must match the queue head.
    always @(negedge clk) begin
        if (!reset && out_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected out_enable", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                mon_exp = exp_q.pop_front();
                check("out_data", 32'(out_data), 32'(mon_exp));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns 1 time unit after the handshake edge.
    task automatic send(input logic [7:0] b, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_byte  = b;
        in_last  = last;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) check("in_ready timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        step();
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        check({tag, " out_enable"}, 32'(out_enable), 32'd0);
        check({tag, " out_data"}, 32'(out_data), 32'd0);
        check({tag, " fifo_level"}, 32'(fifo_level), 32'd0);
        check({tag, " key_len_err"}, 32'(key_len_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        repeat (2) step();
        check_reset_outputs("reset");
        reset = 1'b0;
        step();

`ifndef BFC_DUAL_HASH_EN
        // Single-byte key 0x00: h=0x4B, index 0xF, pulse two edges after handshake.
        exp_q.push_back(8'h0F);
        send(8'h00, 1'b1);
        check("t1 E0 out_enable", 32'(out_enable), 32'd0);
        check("t1 E0 in_ready", 32'(in_ready), 32'd0);
        step();
        check("t1 E1 out_enable", 32'(out_enable), 32'd0);
        check("t1 E1 fifo_level", 32'(fifo_level), 32'd1);
        step();
        check("t1 E2 out_enable", 32'(out_enable), 32'd1);
        step();
        check("t1 E3 out_enable", 32'(out_enable), 32'd0);
        check("t1 E3 fifo_level", 32'(fifo_level), 32'd0);

        // Two-byte key: h=0x86, index 0xE; in_ready low for exactly one cycle.
        exp_q.push_back(8'h0E);
        send(8'h12, 1'b0);
        check("t2 in_ready mid-key", 32'(in_ready), 32'd1);
        send(8'h34, 1'b1);
        check("t2 in_ready in EMIT", 32'(in_ready), 32'd0);
        step();
        check("t2 in_ready after EMIT", 32'(in_ready), 32'd1);
        drain();
        check("t2 key_len_err", 32'(key_len_err), 32'd0);

        // Hold: four keys buffered, fifth stalls in EMIT, then five back-to-back pulses.
        hold = 1'b1;
        exp_q.push_back(8'h0F);
        exp_q.push_back(8'h0C);
        exp_q.push_back(8'h08);
        exp_q.push_back(8'h0E);
        exp_q.push_back(8'h07);
        send(8'h00, 1'b1);
        send(8'h12, 1'b1);
        send(8'h34, 1'b1);
        send(8'h01, 1'b1);
        send(8'h80, 1'b1);
        repeat (3) step();
        check("t3 fifo_level full", 32'(fifo_level), 32'd4);
        check("t3 in_ready stalled", 32'(in_ready), 32'd0);
        check("t3 out_enable held", 32'(out_enable), 32'd0);
        hold = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("t3 pulse %0d", i), 32'(out_enable), 32'd1);
        end
        step();
        check("t3 out_enable after burst", 32'(out_enable), 32'd0);
        check("t3 fifo_level empty", 32'(fifo_level), 32'd0);
        check("t3 in_ready", 32'(in_ready), 32'd1);
        check("t3 queue", 32'(exp_q.size()), 32'd0);

        // Over-long key: first four bytes -> index 0xD, fifth byte alone -> 0xA.
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        check("t4 key_len_err before limit", 32'(key_len_err), 32'd0);
        send(8'h04, 1'b0);
        check("t4 key_len_err at limit", 32'(key_len_err), 32'd1);
        send(8'h05, 1'b1);
        drain();
        check("t4 key_len_err sticky", 32'(key_len_err), 32'd1);

        // Reset mid-key discards it; the next key hashes from SEED (0x34 -> 0x8).
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        reset = 1'b1;
        step();
        check_reset_outputs("t5");
        reset = 1'b0;
        exp_q.push_back(8'h08);
        send(8'h34, 1'b1);
        drain();
`else
        // Dual hash: {0x12} -> 0xC then 0xA; {0x00} -> 0xF, 0x9; {0x34} -> 0x8, 0xE.
        hold = 1'b1;
        exp_q.push_back(8'h0C);
        exp_q.push_back(8'h0A);
        exp_q.push_back(8'h0F);
        exp_q.push_back(8'h09);
        exp_q.push_back(8'h08);
        exp_q.push_back(8'h0E);
        send(8'h12, 1'b1);
        step();
        check("t6 fifo_level one key", 32'(fifo_level), 32'd2);
        send(8'h00, 1'b1);
        send(8'h34, 1'b1);
        repeat (3) step();
        check("t6 fifo_level full", 32'(fifo_level), 32'd4);
        check("t6 in_ready stalled", 32'(in_ready), 32'd0);
        hold = 1'b0;
        step();
        hold = 1'b1;
        repeat (3) step();
        check("t6 fifo_level one free", 32'(fifo_level), 32'd3);
        check("t6 in_ready one free", 32'(in_ready), 32'd0);
        check("t6 queue one popped", 32'(exp_q.size()), 32'd5);
        hold = 1'b0;
        drain();
        check("t6 fifo_level empty", 32'(fifo_level), 32'd0);
        check("t6 in_ready", 32'(in_ready), 32'd1);
`endif

        repeat (5) step();
        check("leftover expected", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
